// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow clock s_clk in i_clk cycles and flags a stopped clock.
// Latency: 2 i_clk edges from s_clk sample to o_valid/o_stall, 3 with CLOCK_PERIOD_METER_SYNC_EN defined.
// No backpressure: o_valid is a one-cycle pulse, results hold until the next measurement.
module clock_period_meter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             s_clk,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             o_valid,
    output logic             o_stall
);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH_PH   = 2'd1,
        LOW_PH    = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] IDLE_LIM = WIDTH'(TIMEOUT - 1);

    logic s_q;
    logic s_d;
    logic rise;
    logic fall;
    logic timeout_hit;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_per;
    logic [WIDTH-1:0] cnt_per_nxt;
    logic [WIDTH-1:0] cnt_hi;
    logic [WIDTH-1:0] cnt_hi_nxt;
    logic [WIDTH-1:0] idle_cnt;
    logic [WIDTH-1:0] idle_cnt_nxt;
    logic [WIDTH-1:0] period_nxt;
    logic [WIDTH-1:0] high_time_nxt;
    logic             valid_nxt;
    logic             stall_nxt;

`ifdef CLOCK_PERIOD_METER_SYNC_EN
    // Two-flop synchronizer for an s_clk asynchronous to i_clk.
    logic s_meta;

    always_ff @(posedge i_clk) begin
        if (!reset) begin
            s_meta <= 1'b0;
            s_q    <= 1'b0;
        end else begin
            s_meta <= s_clk;
            s_q    <= s_meta;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (!reset) begin
            s_q <= 1'b0;
        end else begin
            s_q <= s_clk;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!reset) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s_q;
        end
    end

    assign rise = s_q & ~s_d;
    assign fall = ~s_q & s_d;

    // An edge in the threshold cycle takes priority over the timeout.
    assign timeout_hit = (idle_cnt == IDLE_LIM) && !rise && !fall;

    always_comb begin
        state_nxt     = state;
        cnt_per_nxt   = cnt_per;
        cnt_hi_nxt    = cnt_hi;
        period_nxt    = period;
        high_time_nxt = high_time;
        valid_nxt     = 1'b0;
        stall_nxt     = o_stall;

        if (rise || fall) begin
            idle_cnt_nxt = '0;
        end else if (timeout_hit || (state == WAIT_RISE && o_stall)) begin
            idle_cnt_nxt = idle_cnt;
        end else begin
            idle_cnt_nxt = idle_cnt + ONE;
        end

        case (state)
            WAIT_RISE: begin
                cnt_per_nxt = '0;
                cnt_hi_nxt  = '0;
                if (rise) begin
                    cnt_per_nxt = ONE;
                    cnt_hi_nxt  = ONE;
                    stall_nxt   = 1'b0;
                    state_nxt   = HIGH_PH;
                end
            end
            HIGH_PH: begin
                cnt_per_nxt = cnt_per + ONE;
                if (fall) begin
                    state_nxt = LOW_PH;
                end else begin
                    cnt_hi_nxt = cnt_hi + ONE;
                end
            end
            LOW_PH: begin
                if (rise) begin
                    period_nxt    = cnt_per;
                    high_time_nxt = cnt_hi;
                    valid_nxt     = 1'b1;
                    cnt_per_nxt   = ONE;
                    cnt_hi_nxt    = ONE;
                    state_nxt     = HIGH_PH;
                end else begin
                    cnt_per_nxt = cnt_per + ONE;
                end
            end
            default: begin
                state_nxt   = WAIT_RISE;
                cnt_per_nxt = '0;
                cnt_hi_nxt  = '0;
            end
        endcase

        if (timeout_hit) begin
            stall_nxt   = 1'b1;
            state_nxt   = WAIT_RISE;
            cnt_per_nxt = '0;
            cnt_hi_nxt  = '0;
            valid_nxt   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!reset) begin
            state     <= WAIT_RISE;
            cnt_per   <= '0;
            cnt_hi    <= '0;
            idle_cnt  <= '0;
            period    <= '0;
            high_time <= '0;
            o_valid   <= 1'b0;
            o_stall   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt_per   <= cnt_per_nxt;
            cnt_hi    <= cnt_hi_nxt;
            idle_cnt  <= idle_cnt_nxt;
            period    <= period_nxt;
            high_time <= high_time_nxt;
            o_valid   <= valid_nxt;
            o_stall   <= stall_nxt;
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed self-checking bench for clock_period_meter with a synchronous s_clk and TIMEOUT=50.
// Honours CLOCK_PERIOD_METER_SYNC_EN for the one-cycle latency difference.
module tb_clock_period_meter;

    localparam int W  = 16;
    localparam int TO = 50;
`ifdef CLOCK_PERIOD_METER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic         i_clk = 1'b0;
    logic         reset = 1'b0;
    logic         s_clk = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         o_valid;
    logic         o_stall;

    int           tests = 0;
    int           fails = 0;
    int           cyc_n = 0;
    int           base;
    logic [W-1:0] per_q[$];
    logic [W-1:0] hi_q[$];
    int           vcyc_q[$];
    bit           stall_seen;

    clock_period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .i_clk    (i_clk),
        .reset    (reset),
        .s_clk    (s_clk),
        .period   (period),
        .high_time(high_time),
        .o_valid  (o_valid),
        .o_stall  (o_stall)
    );

    always #5 i_clk = ~i_clk;

    // Drive s_clk for one i_clk cycle and log what the DUT reports after the edge.
    task automatic cyc(input logic lvl);
        s_clk = lvl;
        @(posedge i_clk);
        #1;
        cyc_n++;
        if (o_valid === 1'b1) begin
            per_q.push_back(period);
            hi_q.push_back(high_time);
            vcyc_q.push_back(cyc_n);
        end
        if (o_stall === 1'b1) stall_seen = 1'b1;
    endtask

    task automatic clear_log();
        per_q.delete();
        hi_q.delete();
        vcyc_q.delete();
        stall_seen = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) cyc(1'b0);
        reset = 1'b1;
        repeat (2) cyc(1'b0);
        clear_log();
    endtask

    task automatic run_wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (hi) cyc(1'b1);
            repeat (lo) cyc(1'b0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_log();
        for (int i = 0; i < 6; i++) cyc(1'(i % 2));
        tests++; if (period !== 16'd0) begin fails++; $display("FAIL reset_period: got %0d expected 0", period); end
        tests++; if (high_time !== 16'd0) begin fails++; $display("FAIL reset_high: got %0d expected 0", high_time); end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        tests++; if (o_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", o_stall); end
        s_clk = 1'b0;
        cyc(1'b0);
        reset = 1'b1;
        repeat (2) cyc(1'b0);
        clear_log();
        base = cyc_n;
        run_wave(5, 5, 2);
        tests++; if (per_q.size() !== 1) begin fails++; $display("FAIL reset_first_rise_count: got %0d expected 1", per_q.size()); end
        if (per_q.size() > 0) begin
            tests++; if (vcyc_q[0] !== base + 10 + LAT) begin fails++; $display("FAIL reset_first_valid_cycle: got %0d expected %0d", vcyc_q[0], base + 10 + LAT); end
        end
    endtask

    task automatic test_steady();
        do_reset();
        base = cyc_n;
        run_wave(5, 5, 4);
        tests++; if (per_q.size() !== 3) begin fails++; $display("FAIL steady_count: got %0d expected 3", per_q.size()); end
        for (int i = 0; i < per_q.size(); i++) begin
            tests++; if (per_q[i] !== 16'd10) begin fails++; $display("FAIL steady_period[%0d]: got %0d expected 10", i, per_q[i]); end
            tests++; if (hi_q[i] !== 16'd5) begin fails++; $display("FAIL steady_high[%0d]: got %0d expected 5", i, hi_q[i]); end
            tests++; if (vcyc_q[i] !== base + 10 * (i + 1) + LAT) begin fails++; $display("FAIL steady_cycle[%0d]: got %0d expected %0d", i, vcyc_q[i], base + 10 * (i + 1) + LAT); end
        end
        tests++; if (stall_seen !== 1'b0) begin fails++; $display("FAIL steady_stall: got %b expected 0", stall_seen); end
    endtask

    task automatic test_duty();
        do_reset();
        run_wave(1, 9, 4);
        tests++; if (per_q.size() !== 3) begin fails++; $display("FAIL duty19_count: got %0d expected 3", per_q.size()); end
        for (int i = 0; i < per_q.size(); i++) begin
            tests++; if (per_q[i] !== 16'd10) begin fails++; $display("FAIL duty19_period[%0d]: got %0d expected 10", i, per_q[i]); end
            tests++; if (hi_q[i] !== 16'd1) begin fails++; $display("FAIL duty19_high[%0d]: got %0d expected 1", i, hi_q[i]); end
        end
        do_reset();
        run_wave(9, 1, 4);
        tests++; if (per_q.size() !== 3) begin fails++; $display("FAIL duty91_count: got %0d expected 3", per_q.size()); end
        for (int i = 0; i < per_q.size(); i++) begin
            tests++; if (per_q[i] !== 16'd10) begin fails++; $display("FAIL duty91_period[%0d]: got %0d expected 10", i, per_q[i]); end
            tests++; if (hi_q[i] !== 16'd9) begin fails++; $display("FAIL duty91_high[%0d]: got %0d expected 9", i, hi_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        base = cyc_n;
        run_wave(1, 1, 5);
        tests++; if (per_q.size() !== 4) begin fails++; $display("FAIL min_count: got %0d expected 4", per_q.size()); end
        for (int i = 0; i < per_q.size(); i++) begin
            tests++; if (per_q[i] !== 16'd2) begin fails++; $display("FAIL min_period[%0d]: got %0d expected 2", i, per_q[i]); end
            tests++; if (hi_q[i] !== 16'd1) begin fails++; $display("FAIL min_high[%0d]: got %0d expected 1", i, hi_q[i]); end
            tests++; if (vcyc_q[i] !== base + 2 * (i + 1) + LAT) begin fails++; $display("FAIL min_cycle[%0d]: got %0d expected %0d", i, vcyc_q[i], base + 2 * (i + 1) + LAT); end
        end
    endtask

    task automatic test_stall();
        int first_j;
        do_reset();
        run_wave(5, 5, 2);
        clear_log();
        first_j = -1;
        for (int j = 0; j < LAT + 60; j++) begin
            cyc(1'b1);
            if (o_stall === 1'b1 && first_j < 0) first_j = j;
        end
        tests++; if (first_j !== LAT + 49) begin fails++; $display("FAIL stall_onset: got %0d expected %0d", first_j, LAT + 49); end
        tests++; if (per_q.size() !== 1) begin fails++; $display("FAIL stall_valid_count: got %0d expected 1", per_q.size()); end
        tests++; if (period !== 16'd10) begin fails++; $display("FAIL stall_period_kept: got %0d expected 10", period); end
        tests++; if (high_time !== 16'd5) begin fails++; $display("FAIL stall_high_kept: got %0d expected 5", high_time); end
        clear_log();
        repeat (5) cyc(1'b0);
        tests++; if (o_stall !== 1'b1) begin fails++; $display("FAIL stall_hold_low: got %b expected 1", o_stall); end
        repeat (LAT) cyc(1'b1);
        tests++; if (o_stall !== 1'b0) begin fails++; $display("FAIL stall_clear: got %b expected 0", o_stall); end
        repeat (5 - LAT) cyc(1'b1);
        repeat (5) cyc(1'b0);
        tests++; if (per_q.size() !== 0) begin fails++; $display("FAIL stall_restart_novalid: got %0d expected 0", per_q.size()); end
        repeat (LAT) cyc(1'b1);
        tests++; if (per_q.size() !== 1) begin fails++; $display("FAIL stall_restart_count: got %0d expected 1", per_q.size()); end
        if (per_q.size() > 0) begin
            tests++; if (per_q[0] !== 16'd10) begin fails++; $display("FAIL stall_restart_period: got %0d expected 10", per_q[0]); end
            tests++; if (hi_q[0] !== 16'd5) begin fails++; $display("FAIL stall_restart_high: got %0d expected 5", hi_q[0]); end
        end
    endtask

    task automatic test_threshold();
        logic [W-1:0] exp_per[3];
        logic [W-1:0] exp_hi[3];
        exp_per[0] = 16'd50; exp_hi[0] = 16'd25;
        exp_per[1] = 16'd50; exp_hi[1] = 16'd25;
        exp_per[2] = 16'd60; exp_hi[2] = 16'd50;
        do_reset();
        run_wave(25, 25, 2);
        repeat (50) cyc(1'b1);
        repeat (10) cyc(1'b0);
        repeat (LAT) cyc(1'b1);
        tests++; if (per_q.size() !== 3) begin fails++; $display("FAIL thr_count: got %0d expected 3", per_q.size()); end
        for (int i = 0; i < per_q.size() && i < 3; i++) begin
            tests++; if (per_q[i] !== exp_per[i]) begin fails++; $display("FAIL thr_period[%0d]: got %0d expected %0d", i, per_q[i], exp_per[i]); end
            tests++; if (hi_q[i] !== exp_hi[i]) begin fails++; $display("FAIL thr_high[%0d]: got %0d expected %0d", i, hi_q[i], exp_hi[i]); end
        end
        tests++; if (stall_seen !== 1'b0) begin fails++; $display("FAIL thr_stall: got %b expected 0", stall_seen); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_wave(5, 5, 2);
        repeat (3) cyc(1'b1);
        tests++; if (period !== 16'd10) begin fails++; $display("FAIL mid_pre_period: got %0d expected 10", period); end
        reset = 1'b0;
        repeat (2) cyc(1'b1);
        tests++; if (period !== 16'd0) begin fails++; $display("FAIL mid_period: got %0d expected 0", period); end
        tests++; if (high_time !== 16'd0) begin fails++; $display("FAIL mid_high: got %0d expected 0", high_time); end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b expected 0", o_valid); end
        tests++; if (o_stall !== 1'b0) begin fails++; $display("FAIL mid_stall: got %b expected 0", o_stall); end
        cyc(1'b0);
        reset = 1'b1;
        repeat (3) cyc(1'b0);
        clear_log();
        base = cyc_n;
        run_wave(5, 5, 3);
        tests++; if (per_q.size() !== 2) begin fails++; $display("FAIL mid_count: got %0d expected 2", per_q.size()); end
        for (int i = 0; i < per_q.size(); i++) begin
            tests++; if (per_q[i] !== 16'd10) begin fails++; $display("FAIL mid_period_after[%0d]: got %0d expected 10", i, per_q[i]); end
            tests++; if (hi_q[i] !== 16'd5) begin fails++; $display("FAIL mid_high_after[%0d]: got %0d expected 5", i, hi_q[i]); end
            tests++; if (vcyc_q[i] !== base + 10 * (i + 1) + LAT) begin fails++; $display("FAIL mid_cycle[%0d]: got %0d expected %0d", i, vcyc_q[i], base + 10 * (i + 1) + LAT); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_steady();
        test_duty();
        test_back_to_back();
        test_stall();
        test_threshold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
